rf_writeback_ctrl: RTL
======================

// Module: rf_writeback_ctrl
// PURPOSE
//  Writeback-side driver of the 32x32 register file write port (wr_en/wr_reg/data).
//  Accepts results from the ALU path and the load path, queues them and arbitrates them onto the single write port.
//  Keeps a per-register pending scoreboard so decode can stall on RAW hazards.
//  Sits between the MEM/WB stage and the register file.
// PARAMETERS
//  DATA_W  32  result/register data width
//  ADDR_W  5   register index width (NUM_REGS = 2**ADDR_W)
//  DEPTH   4   write-queue entries; power of 2, >=2
//  CNT_W   2   per-register outstanding-producer counter width
// PORTS
//  clk          in   1        clock; all state on posedge
//  res          in   1        synchronous active-high reset
//  alu_valid    in   1        ALU result offered
//  alu_ready    out  1        ALU result accepted this edge
//  alu_rd       in   ADDR_W   ALU destination register
//  alu_data     in   DATA_W   ALU result
//  ld_valid     in   1        load result offered
//  ld_ready     out  1        load result accepted this edge
//  ld_rd        in   ADDR_W   load destination register
//  ld_data      in   DATA_W   load data
//  wr_hold      in   1        write port borrowed externally; pop blocked
//  wr_en        out  1        register-file write enable
//  wr_reg       out  ADDR_W   register-file write index
//  wr_data      out  DATA_W   register-file write data
//  issue_valid  in   1        decode issued an instruction writing issue_rd
//  issue_rd     in   ADDR_W   destination of issued instruction
//  issue_ready  out  1        cnt[issue_rd] != max; decode must stall otherwise
//  pending      out  NUM_REGS bit r = 1 while register r has outstanding producers
// BEHAVIOUR
//  - Reset (res=1 at posedge): queue emptied; output stage invalid; all counters 0.
//    wr_en=0, wr_reg=0, wr_data=0, pending=0.
//    alu_ready=ld_ready=issue_ready=1 the cycle after reset. Queued writes in flight at reset are dropped.
//  - Accept: ld_ready = (count<DEPTH); alu_ready = (count<DEPTH) & ~ld_valid. Load has fixed priority.
//    Readies depend on count only; no same-edge pop credit when full.
//  - At most one enqueue per edge. Accepted entries with rd==0 are consumed and discarded:
//    never enqueued, never written.
//  - Output stage: one register {v,rd,data}. At each edge with wr_hold=0, it loads the queue head
//    (pop) if count>0, else v<=0. With wr_hold=1, the output stage and queue hold.
//  - wr_en = v & ~wr_hold (combinational gate). wr_reg/wr_data come from the output stage.
//  - Latency: accepted at edge k into an empty queue -> wr_en=1 during cycle k+1..k+2 (after edge k+1);
//    register file commits at edge k+2. Throughput is 1 write/cycle. Write order = accept order.
//  - Scoreboard: cnt[r] +1 at an edge with issue_valid & issue_ready & issue_rd!=0.
//    cnt[r] -1 at an edge with wr_en & wr_reg==r. Both on the same r -> unchanged.
//    pending[r] = (cnt[r]!=0); pending[0] is always 0.
//  - issue_valid with issue_ready=0 is ignored, and the counter does not wrap.
//    A decrement at cnt=0 (spurious write) saturates at 0.
// CONFIGURATION
//  RF_WB_FWD_EN defined: adds inputs rd_a, rd_b (ADDR_W) and outputs fwd_a_hit, fwd_b_hit (1)
//    and fwd_a_data, fwd_b_data (DATA_W), all combinational.
//    hit=1 when the index matches a valid output-stage or queue entry and the index != 0.
//    data is taken from the youngest matching entry (queue tail side first, output stage last).
//  RF_WB_FWD_EN undefined: these ports and the search logic are absent. Decode relies on pending only.
// STRUCTURE
//  Package rf_wb_pkg: DATA_W, ADDR_W, NUM_REGS, DEPTH defaults;
//    typedef wb_entry_t {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data;}.
//  Sub-module wb_fifo: sync FIFO of wb_entry_t with push/pop/count, reset via res,
//    entry array exposed for forwarding. Arbiter, output stage and scoreboard live in the top.
// TESTING
//  1 reset; alu_valid=1 rd=5 data=0xDEADBEEF one cycle -> alu_ready=1;
//    wr_en=1, wr_reg=5, wr_data=0xDEADBEEF exactly one cycle, two edges after accept.
//  2 ld (rd=3, 0x11) and alu (rd=4, 0x22) valid together -> ld accepted, alu_ready=0;
//    alu accepted next edge; writes reg3 then reg4 on consecutive cycles.
//  3 wr_hold=1, push 4 entries -> 4th accepted, then ld_ready=alu_ready=0, wr_en=0;
//    release hold -> 4 writes in order, readies return.
//  4 alu rd=0 data=0xFFFF -> accepted, no wr_en ever asserted; pending[0] stays 0.
//  5 issue rd=7 three times -> pending[7]=1, issue_ready=0 for rd=7;
//    three writes to reg7 -> pending[7]=0 after the third; inc+dec on the same edge leaves cnt unchanged.
//  6 queue 3 entries under wr_hold, assert res one cycle -> no wr_en afterwards, pending=0;
//    FWD_EN build: rd_a=9 with two queued reg9 writes -> fwd_a_data equals the younger value.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and the write-queue entry type for the register-file writeback controller.
package rf_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int DEPTH    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Bundle of producer, write-port and decode signals around the writeback controller.
// RF_WB_FWD_EN adds the two forwarding lookup ports.
interface rf_writeback_ctrl_if;
  import rf_wb_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                ld_valid;
  logic                ld_ready;
  logic [ADDR_W-1:0]   ld_rd;
  logic [DATA_W-1:0]   ld_data;
  logic                wr_hold;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_reg;
  logic [DATA_W-1:0]   wr_data;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_ready;
  logic [NUM_REGS-1:0] pending;
`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0]   rd_a;
  logic [ADDR_W-1:0]   rd_b;
  logic                fwd_a_hit;
  logic                fwd_b_hit;
  logic [DATA_W-1:0]   fwd_a_data;
  logic [DATA_W-1:0]   fwd_b_data;
`endif

  modport slave (
`ifdef RF_WB_FWD_EN
    input  rd_a, rd_b,
    output fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data,
`endif
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  wr_hold, issue_valid, issue_rd,
    output alu_ready, ld_ready, wr_en, wr_reg, wr_data, issue_ready, pending
  );

  modport master (
`ifdef RF_WB_FWD_EN
    output rd_a, rd_b,
    input  fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data,
`endif
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output wr_hold, issue_valid, issue_rd,
    input  alu_ready, ld_ready, wr_en, wr_reg, wr_data, issue_ready, pending
  );

endinterface

// File: rtl/rf_writeback_ctrl_fifo.sv
// Synchronous write queue of wb_entry_t; storage is exposed so the top can search it for forwarding.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = rf_wb_pkg::DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic [PTR_W-1:0] rd_ptr,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & (count_reg != (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop & (count_reg != '0);

  // Storage carries no reset: the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign head   = mem_reg[rd_ptr_reg];
  assign count  = count_reg;
  assign rd_ptr = rd_ptr_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
    assign entries[gi] = mem_reg[gi];
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: load/ALU arbitration, write queue, output stage and RAW scoreboard.
// Build option RF_WB_FWD_EN adds combinational forwarding lookups over the queued writes.
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = rf_wb_pkg::DEPTH,
  parameter int CNT_W = 2
) (
  input logic                clk,
  input logic                res,
  rf_writeback_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_entry_t        in_entry;
  wb_entry_t        head_entry;
  wb_entry_t        q_entries [DEPTH];
  logic [PTR_W:0]   q_count;
  logic [PTR_W-1:0] q_rd_ptr;
  logic             q_full;
  logic             q_nonempty;
  logic             ld_acc;
  logic             alu_acc;
  logic             push;
  logic             pop;

  logic              out_v_reg;
  logic [ADDR_W-1:0] out_rd_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              wr_en_int;

  logic                issue_ready_int;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pend_vec;
  logic [NUM_REGS-1:0] full_vec;

  // Readiness looks at occupancy only, so a full queue never takes credit for a same-edge pop.
  assign q_full     = (q_count == (PTR_W+1)'(DEPTH));
  assign q_nonempty = (q_count != '0);
  assign ld_acc     = bus.ld_valid & ~q_full;
  assign alu_acc    = bus.alu_valid & ~q_full & ~bus.ld_valid;

  always_comb begin
    in_entry.rd   = ld_acc ? bus.ld_rd   : bus.alu_rd;
    in_entry.data = ld_acc ? bus.ld_data : bus.alu_data;
  end

  // Results aimed at r0 are handshaken but dropped here.
  assign push = (ld_acc | alu_acc) & (in_entry.rd != '0);
  assign pop  = ~bus.wr_hold & q_nonempty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .res        (res),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head_entry),
    .count      (q_count),
    .rd_ptr     (q_rd_ptr),
    .entries    (q_entries)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      out_v_reg    <= 1'b0;
      out_rd_reg   <= '0;
      out_data_reg <= '0;
    end else if (!bus.wr_hold) begin
      if (q_nonempty) begin
        out_v_reg    <= 1'b1;
        out_rd_reg   <= head_entry.rd;
        out_data_reg <= head_entry.data;
      end else begin
        out_v_reg <= 1'b0;
      end
    end
  end

  assign wr_en_int     = out_v_reg & ~bus.wr_hold;
  assign bus.wr_en     = wr_en_int;
  assign bus.wr_reg    = out_rd_reg;
  assign bus.wr_data   = out_data_reg;
  assign bus.ld_ready  = ~q_full;
  assign bus.alu_ready = ~q_full & ~bus.ld_valid;

  assign issue_ready_int = ~full_vec[bus.issue_rd];
  assign issue_fire      = bus.issue_valid & issue_ready_int & (bus.issue_rd != '0);
  assign bus.issue_ready = issue_ready_int;
  assign bus.pending     = pend_vec;

  // One saturating producer counter per architectural register; r0 has none.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    if (gi == 0) begin : g_zero
      assign pend_vec[gi] = 1'b0;
      assign full_vec[gi] = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             inc;
      logic             dec;

      assign inc = issue_fire & (bus.issue_rd == ADDR_W'(gi));
      assign dec = wr_en_int & (out_rd_reg == ADDR_W'(gi));

      always_ff @(posedge clk) begin
        if (res) begin
          cnt_reg <= '0;
        end else if (inc && !dec && cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end

      assign pend_vec[gi] = (cnt_reg != '0);
      assign full_vec[gi] = (cnt_reg == CNT_MAX);
    end
  end

`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_rd [2];

  assign fwd_rd[0] = bus.rd_a;
  assign fwd_rd[1] = bus.rd_b;

  // Scan oldest to youngest so the last match left standing is the youngest writer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (out_v_reg && out_rd_reg == fwd_rd[gi]) begin
        hit  = 1'b1;
        data = out_data_reg;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = q_rd_ptr + PTR_W'(i);
        if (((PTR_W+1)'(i) < q_count) && (q_entries[idx].rd == fwd_rd[gi])) begin
          hit  = 1'b1;
          data = q_entries[idx].data;
        end
      end
      if (fwd_rd[gi] == '0) begin
        hit = 1'b0;
      end
    end
  end

  assign bus.fwd_a_hit  = g_fwd[0].hit;
  assign bus.fwd_a_data = g_fwd[0].data;
  assign bus.fwd_b_hit  = g_fwd[1].hit;
  assign bus.fwd_b_data = g_fwd[1].data;
`endif

endmodule
